// File: rtl/uart_cmd_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_assembler_if
//  Purpose  : Bundles the byte-input, command-output and status signals of
//             the UART command assembler.
//  Ports    : RX_VALID/RX_BYTE - received UART byte strobe and data
//             FLUSH            - synchronous clear request
//             CMD_READY        - consumer accepts the head word
//             CMD_VALID/CMD_DATA - FIFO head word and its valid flag
//             FIFO_COUNT, BYTE_CNT, OVERFLOW, TIMEOUT_ERR, CSUM_ERR - status
//  Modports : master - the assembler itself; slave - the surrounding logic
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_assembler_if #(
  parameter int BYTES = 3,
  parameter int DEPTH = 16
);
  logic                       RX_VALID;
  logic [7:0]                 RX_BYTE;
  logic                       FLUSH;
  logic                       CMD_READY;
  logic                       CMD_VALID;
  logic [BYTES*8-1:0]         CMD_DATA;
  logic [$clog2(DEPTH):0]     FIFO_COUNT;
  logic [$clog2(BYTES+1)-1:0] BYTE_CNT;
  logic                       OVERFLOW;
  logic                       TIMEOUT_ERR;
  logic                       CSUM_ERR;

  modport master (
    input  RX_VALID, RX_BYTE, FLUSH, CMD_READY,
    output CMD_VALID, CMD_DATA, FIFO_COUNT, BYTE_CNT, OVERFLOW, TIMEOUT_ERR, CSUM_ERR
  );

  modport slave (
    output RX_VALID, RX_BYTE, FLUSH, CMD_READY,
    input  CMD_VALID, CMD_DATA, FIFO_COUNT, BYTE_CNT, OVERFLOW, TIMEOUT_ERR, CSUM_ERR
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_assembler
//  Purpose  : Packs received UART bytes little-endian into BYTES-wide command
//             words, discards partial words after an idle timeout and queues
//             complete words in a DEPTH-entry show-ahead FIFO read through a
//             valid/ready handshake.
//  Ports    : CLOCK_50 - system clock (rising edge)
//             RST      - asynchronous active-high reset
//             cmd      - uart_cmd_assembler_if.master (byte input, command
//                        output, FIFO/assembly status)
//  Options  : CHECKSUM_EN - when defined, each word is followed by an XOR
//             checksum byte; mismatching words are dropped with CSUM_ERR.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler #(
  parameter int BYTES          = 3,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  wire logic             CLOCK_50,
  input  wire logic             RST,
  uart_cmd_assembler_if.master  cmd
);

  localparam int W   = BYTES * 8;
  localparam int BCW = $clog2(BYTES + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  // Timer only needs to reach TIMEOUT_CYCLES-1.
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [0:0] {
    ASSEMBLE = 1'b0
`ifdef CHECKSUM_EN
    , CHECK  = 1'b1
`endif
  } state_t;

  state_t           state, state_next;
  logic [BCW-1:0]   byte_cnt, byte_cnt_next;
  logic [W-1:0]     asm_word, asm_next, ins_word, push_data;
  logic [TW-1:0]    timer, timer_next;
  logic             timeout_next, csum_err_next;
  logic             timeout_err, csum_err;
  logic             push_req, timer_active;
`ifdef CHECKSUM_EN
  logic [7:0]       csum_acc, csum_next;
`endif

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             full, do_pop, do_push;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) state <= ASSEMBLE;
    else     state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state, assembly and timeout logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    asm_next      = asm_word;
    timer_next    = timer;
    timeout_next  = 1'b0;
    csum_err_next = 1'b0;
    push_req      = 1'b0;
    push_data     = asm_word;
`ifdef CHECKSUM_EN
    csum_next     = csum_acc;
`endif

    // Current partial word with the incoming byte dropped into its lane.
    ins_word = asm_word;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_cnt == BCW'(k)) ins_word[8*k +: 8] = cmd.RX_BYTE;
    end

    timer_active = (byte_cnt != '0) || (state != ASSEMBLE);

    if (cmd.FLUSH) begin
      state_next    = ASSEMBLE;
      byte_cnt_next = '0;
      asm_next      = '0;
      timer_next    = '0;
`ifdef CHECKSUM_EN
      csum_next     = '0;
`endif
    end else if (cmd.RX_VALID) begin
      // A byte in the timeout cycle wins over the timeout.
      timer_next = '0;
      case (state)
        ASSEMBLE: begin
`ifdef CHECKSUM_EN
          csum_next = csum_acc ^ cmd.RX_BYTE;
`endif
          if (byte_cnt == BCW'(BYTES - 1)) begin
            byte_cnt_next = '0;
`ifdef CHECKSUM_EN
            asm_next   = ins_word;
            state_next = CHECK;
`else
            asm_next   = '0;
            push_req   = 1'b1;
            push_data  = ins_word;
`endif
          end else begin
            byte_cnt_next = byte_cnt + BCW'(1);
            asm_next      = ins_word;
          end
        end
`ifdef CHECKSUM_EN
        CHECK: begin
          state_next = ASSEMBLE;
          asm_next   = '0;
          csum_next  = '0;
          if (cmd.RX_BYTE == csum_acc) begin
            push_req  = 1'b1;
            push_data = asm_word;
          end else begin
            csum_err_next = 1'b1;
          end
        end
`endif
        default: state_next = ASSEMBLE;
      endcase
    end else if ((TIMEOUT_CYCLES != 0) && timer_active) begin
      if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_next  = 1'b1;
        state_next    = ASSEMBLE;
        byte_cnt_next = '0;
        asm_next      = '0;
        timer_next    = '0;
`ifdef CHECKSUM_EN
        csum_next     = '0;
`endif
      end else begin
        timer_next = timer + TW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control: a pop frees a slot for a push in the same cycle.
  // --------------------------------------------------------------------------
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = (count != '0) && cmd.CMD_READY && !cmd.FLUSH;
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      byte_cnt    <= '0;
      asm_word    <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      csum_err    <= 1'b0;
`ifdef CHECKSUM_EN
      csum_acc    <= '0;
`endif
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      byte_cnt    <= byte_cnt_next;
      asm_word    <= asm_next;
      timer       <= timer_next;
      timeout_err <= timeout_next;
      csum_err    <= csum_err_next;
`ifdef CHECKSUM_EN
      csum_acc    <= csum_next;
`endif
      if (cmd.FLUSH) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
        if (push_req && full && !do_pop) overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; the head is masked to zero while empty.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd.CMD_VALID   = (count != '0);
  assign cmd.CMD_DATA    = (count != '0) ? mem[rd_ptr] : '0;
  assign cmd.FIFO_COUNT  = count;
  assign cmd.BYTE_CNT    = byte_cnt;
  assign cmd.OVERFLOW    = overflow;
  assign cmd.TIMEOUT_ERR = timeout_err;
`ifdef CHECKSUM_EN
  assign cmd.CSUM_ERR    = csum_err;
`else
  assign cmd.CSUM_ERR    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_assembler
//  Purpose  : Directed self-checking bench for uart_cmd_assembler with
//             BYTES=3, DEPTH=16, TIMEOUT_CYCLES=100. Expected words are queued
//             as they are sent and compared as they are popped.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_assembler_if #(.BYTES(3), .DEPTH(16)) bus ();

  uart_cmd_assembler #(
    .BYTES          (3),
    .DEPTH          (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .cmd      (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [23:0] q[$];
  logic        m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus. pushw marks the byte that completes a word w.
  task automatic cycle(input bit rv, input logic [7:0] b, input bit rd, input bit fl,
                       input bit pushw, input logic [23:0] w);
    bus.RX_VALID  = rv;
    bus.RX_BYTE   = b;
    bus.CMD_READY = rd;
    bus.FLUSH     = fl;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd && q.size() > 0) begin
        chk("pop_data", 64'(bus.CMD_DATA), 64'(q[0]));
        void'(q.pop_front());
      end
      if (pushw) begin
        if (q.size() < 16) q.push_back(w);
        else               m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.RX_VALID  = 1'b0;
    bus.CMD_READY = 1'b0;
    bus.FLUSH     = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] w, input bit rd_last);
    cycle(1'b1, w[7:0],   1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, w[15:8],  1'b0, 1'b0, 1'b0, 24'h0);
`ifdef CHECKSUM_EN
    cycle(1'b1, w[23:16], 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, w[7:0] ^ w[15:8] ^ w[23:16], rd_last, 1'b0, 1'b1, w);
`else
    cycle(1'b1, w[23:16], rd_last, 1'b0, 1'b1, w);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++)
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("drain_valid", 64'(bus.CMD_VALID), 64'(0));
    chk("drain_count", 64'(bus.FIFO_COUNT), 64'(0));
  endtask

  function automatic logic [23:0] wgen(input int i);
    logic [7:0] a, b, c;
    a = 8'(i + 1);
    b = 8'(i) ^ 8'h5A;
    c = 8'hC0 + 8'(i);
    return {a, b, c};
  endfunction

  initial begin
    int pulses, first;
    bus.RX_VALID  = 1'b0;
    bus.RX_BYTE   = 8'h00;
    bus.CMD_READY = 1'b0;
    bus.FLUSH     = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_valid",  64'(bus.CMD_VALID),   64'(0));
    chk("rst_data",   64'(bus.CMD_DATA),    64'(0));
    chk("rst_count",  64'(bus.FIFO_COUNT),  64'(0));
    chk("rst_bcnt",   64'(bus.BYTE_CNT),    64'(0));
    chk("rst_ovf",    64'(bus.OVERFLOW),    64'(0));
    chk("rst_tmo",    64'(bus.TIMEOUT_ERR), 64'(0));
    chk("rst_csum",   64'(bus.CSUM_ERR),    64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ready while empty is ignored
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("empty_pop_count", 64'(bus.FIFO_COUNT), 64'(0));

    // Test 1: single word latency and packing
    cycle(1'b1, 8'h1B, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("t1_bcnt1", 64'(bus.BYTE_CNT), 64'(1));
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("t1_bcnt2", 64'(bus.BYTE_CNT), 64'(2));
    chk("t1_valid_early", 64'(bus.CMD_VALID), 64'(0));
`ifdef CHECKSUM_EN
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h3B, 1'b0, 1'b0, 1'b1, 24'h30101B);
`else
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 24'h30101B);
`endif
    chk("t1_valid", 64'(bus.CMD_VALID),  64'(1));
    chk("t1_data",  64'(bus.CMD_DATA),   64'h30101B);
    chk("t1_count", 64'(bus.FIFO_COUNT), 64'(1));
    chk("t1_bcnt0", 64'(bus.BYTE_CNT),   64'(0));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("t1_hold",  64'(bus.CMD_DATA),   64'h30101B);
    drain();

    // Test 2: overflow and sticky flag, then FLUSH
    for (int i = 0; i < 16; i++) send_word(wgen(i), 1'b0);
    chk("t2_full_count", 64'(bus.FIFO_COUNT), 64'(16));
    chk("t2_no_ovf",     64'(bus.OVERFLOW),   64'(m_ovf));
    send_word(wgen(16), 1'b0);
    chk("t2_ovf_count", 64'(bus.FIFO_COUNT), 64'(16));
    chk("t2_ovf",       64'(bus.OVERFLOW),   64'(m_ovf));
    chk("t2_ovf_model", 64'(m_ovf),          64'(1));
    drain();
    chk("t2_ovf_sticky", 64'(bus.OVERFLOW), 64'(1));
    send_word(wgen(20), 1'b0);
    send_word(wgen(21), 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 24'h0);
    chk("t2_flush_count", 64'(bus.FIFO_COUNT), 64'(0));
    chk("t2_flush_ovf",   64'(bus.OVERFLOW),   64'(0));
    chk("t2_flush_valid", 64'(bus.CMD_VALID),  64'(0));
    chk("t2_flush_bcnt",  64'(bus.BYTE_CNT),   64'(0));

    // Test 3: push and pop together while full
    for (int i = 0; i < 16; i++) send_word(wgen(32 + i), 1'b0);
    send_word(wgen(48), 1'b1);
    chk("t3_count", 64'(bus.FIFO_COUNT), 64'(16));
    chk("t3_ovf",   64'(bus.OVERFLOW),   64'(0));
    drain();

    // Test 4: inter-byte timeout
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 24'h0);
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 120; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0);
      if (i == 50) chk("t4_bcnt_wait", 64'(bus.BYTE_CNT), 64'(1));
      if (bus.TIMEOUT_ERR === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("t4_pulses", 64'(pulses), 64'(1));
    chk("t4_when",   64'(first >= 99 && first <= 101), 64'(1));
    chk("t4_bcnt",   64'(bus.BYTE_CNT), 64'(0));
    send_word(24'h030201, 1'b0);
    chk("t4_data", 64'(bus.CMD_DATA), 64'h030201);
    drain();

    // Test 5: asynchronous reset mid-word
    for (int i = 0; i < 3; i++) send_word(wgen(60 + i), 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("t5_bcnt_pre", 64'(bus.BYTE_CNT), 64'(2));
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 64'(bus.CMD_VALID),  64'(0));
    chk("t5_data",  64'(bus.CMD_DATA),   64'(0));
    chk("t5_count", 64'(bus.FIFO_COUNT), 64'(0));
    chk("t5_bcnt",  64'(bus.BYTE_CNT),   64'(0));
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    send_word(24'hA5C33C, 1'b0);
    chk("t5_after", 64'(bus.CMD_DATA), 64'hA5C33C);
    drain();

`ifdef CHECKSUM_EN
    // Test 6: checksum match and mismatch
    cycle(1'b1, 8'h1B, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h3B, 1'b0, 1'b0, 1'b1, 24'h30101B);
    chk("t6_good_count", 64'(bus.FIFO_COUNT), 64'(1));
    chk("t6_good_csum",  64'(bus.CSUM_ERR),   64'(0));
    cycle(1'b1, 8'h1B, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("t6_bad_csum",   64'(bus.CSUM_ERR),   64'(1));
    chk("t6_bad_count",  64'(bus.FIFO_COUNT), 64'(1));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("t6_csum_pulse", 64'(bus.CSUM_ERR),   64'(0));
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Parametrised successor to the fixed 3-byte UART command capture: packs a stream of received UART bytes into BYTES-wide command words.
- Drops partial words after an inter-byte timeout.
- Buffers complete words in a DEPTH-entry show-ahead FIFO.
- Presents the FIFO head to the SPI command sequencer through a valid/ready handshake.
- Sits between the UART receiver and the SPI_ADC command path in the top level.

Parameters:
- BYTES, 3, bytes per command word (2..8); CMD_DATA width = BYTES*8.
- DEPTH, 16, FIFO entries (power of two, 2..64).
- TIMEOUT_CYCLES, 500000, CLOCK_50 cycles of idle allowed between bytes of one word (10 ms); 0 disables the timeout.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; all logic on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- RX_VALID  input  1  one-cycle strobe: RX_BYTE holds a new UART byte.
- RX_BYTE  input  8  received byte.
- FLUSH  input  1  synchronous clear of the FIFO, the partial word and OVERFLOW.
- CMD_READY  input  1  consumer accepts the head word (pop).
- CMD_VALID  output  1  FIFO non-empty; CMD_DATA is valid.
- CMD_DATA  output  BYTES*8  FIFO head word.
- FIFO_COUNT  output  $clog2(DEPTH)+1  number of stored words.
- BYTE_CNT  output  $clog2(BYTES+1)  bytes held in the partial word (for LEDs).
- OVERFLOW  output  1  sticky: a complete word was dropped because the FIFO was full.
- TIMEOUT_ERR  output  1  one-cycle pulse when a partial word is discarded.
- CSUM_ERR  output  1  one-cycle checksum-failure pulse; tied 0 when CHECKSUM_EN is undefined.

Behaviour:
- Reset (RST high, asynchronous):
  - All outputs are 0; CMD_DATA = 0.
  - FIFO pointers, byte counter, idle timer and assembly register are cleared.
  - State is ASSEMBLE.
- Byte packing:
  - Little-endian: the first byte goes to [7:0], the k-th byte to [8k+7:8k].
  - BYTE_CNT increments on each RX_VALID.
- States:
  - ASSEMBLE: collects bytes. On the RX_VALID that completes the word, the word is written to the FIFO on that same clock edge, BYTE_CNT returns to 0 and the state stays ASSEMBLE.
  - With CHECKSUM_EN, the completing byte moves the state to CHECK instead.
  - CHECK: waits for the checksum byte, then writes the word or drops it, and returns to ASSEMBLE.
- Latency:
  - The last byte's RX_VALID at edge N makes CMD_VALID high and CMD_DATA valid after edge N when the FIFO was empty.
  - FIFO_COUNT updates at the same edge.
- Handshake:
  - A pop occurs on an edge where CMD_VALID && CMD_READY; CMD_DATA advances to the next entry after that edge.
  - CMD_READY while empty is ignored.
  - CMD_DATA holds its value while CMD_VALID && !CMD_READY.
- Full FIFO:
  - A push with FIFO_COUNT == DEPTH and no pop in the same cycle drops the word and sets OVERFLOW.
  - Push and pop in the same cycle while full: both succeed and the count stays DEPTH.
  - Push and pop in the same cycle otherwise: the count is unchanged.
- Timeout:
  - The idle timer counts only while BYTE_CNT != 0 and is reset by every RX_VALID.
  - When it reaches TIMEOUT_CYCLES, the partial word is discarded, BYTE_CNT goes to 0 and TIMEOUT_ERR pulses for 1 cycle.
  - An RX_VALID in that same cycle wins: the byte is accepted and there is no timeout.
- FLUSH:
  - The next edge clears the FIFO, the partial word, OVERFLOW and the timer.
  - It overrides RX_VALID and CMD_READY in the same cycle.
- OVERFLOW clears only on RST or FLUSH.
- Pointers wrap modulo DEPTH; FIFO_COUNT distinguishes full from empty.

Optional Feature:
- CHECKSUM_EN defined:
  - Each word is followed by one checksum byte equal to the XOR of its BYTES data bytes.
  - A match pushes the word when the checksum byte is accepted.
  - A mismatch drops the word and pulses CSUM_ERR for 1 cycle; the FIFO is untouched.
  - The timeout also applies while in CHECK.
- CHECKSUM_EN undefined: no CHECK state, words are pushed on the last data byte, and CSUM_ERR is constant 0.

Test Plan:
1. BYTES=3: bytes 0x1B,0x10,0x30 with CMD_READY=0 -> CMD_VALID=1 one edge after the third byte, CMD_DATA=24'h30101B, FIFO_COUNT=1.
2. 17 three-byte words with DEPTH=16 and no pops -> FIFO_COUNT=16, OVERFLOW=1, the 17th word absent; then FLUSH -> FIFO_COUNT=0, OVERFLOW=0, CMD_VALID=0.
3. With 16 stored words, the 17th word's last byte arrives with CMD_READY=1 -> pop and push both occur, FIFO_COUNT stays 16, OVERFLOW stays 0, the new word is at the tail.
4. TIMEOUT_CYCLES=100: send 0xAA, wait 100 cycles -> TIMEOUT_ERR pulses once, BYTE_CNT=0; then 0x01,0x02,0x03 -> CMD_DATA=24'h030201.
5. RST asserted mid-word (BYTE_CNT=2) with 3 words stored -> all outputs 0 immediately, without waiting for a clock edge; after release a full word assembles correctly.
6. CHECKSUM_EN: bytes 0x1B,0x10,0x30 then checksum 0x3B -> word pushed; the same data with checksum 0x00 -> CSUM_ERR pulses, FIFO_COUNT unchanged.
